// File: rtl/fifo_bit_packer_pkg.sv
// Shared constants for the 1-bit FIFO read side: default word width and bit-order encoding.
package fifo_bit_packer_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum bit {
    LsbFirst = 1'b0,
    MsbFirst = 1'b1
  } bit_order_e;

endpackage

// File: rtl/fifo_bit_packer.sv
// Pops bits from a 1-bit synchronous FIFO, packs them into WIDTH-bit words and
// presents each word on a valid/ready port through a one-word output register.
module fifo_bit_packer
  import fifo_bit_packer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = MsbFirst
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic                       fifo_data_out,
  output logic                       fifo_rd,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rd_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             full;
  logic             load;
  logic [CntW:0]    occupancy;

  assign full = (cnt_q == CntW'(WIDTH));
  assign load = full && (!valid_q || out_ready);

  // Bits already captured plus the one in flight must leave room for another pop.
  always_comb begin
    occupancy = {1'b0, cnt_q} + {{CntW{1'b0}}, rd_q};
    fifo_rd   = !rst && !fifo_empty && (occupancy < (CntW + 1)'(WIDTH));
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (rd_q) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], fifo_data_out};
      end else begin
        sr_d = {fifo_data_out, sr_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q + CntW'(1);
    end
    if (load) begin
      data_d  = sr_q;
      valid_d = 1'b1;
      cnt_d   = '0;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      rd_q    <= fifo_rd;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign bit_cnt   = cnt_q;

endmodule
